regfile_bypass: RTL and testbench



---
 rtl/regfile_bypass_pkg.sv | 21 ++
 rtl/regfile_bypass_if.sv | 27 ++
 rtl/regfile_reg.sv | 37 +++
 rtl/regfile_bypass.sv | 73 +++++++
 tb/tb_regfile_bypass.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass shared package: sizes, word/select types, per-bit mux.
// Optional same-cycle bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_bypass_pkg;

    localparam int REG_WIDTH = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_SEL_W = 3;

    typedef logic [REG_WIDTH-1:0] reg_word_t;
    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    // Single-bit 2:1 mux: s=0 passes a, s=1 passes b.
    function automatic logic mux2_1(
        input logic a,
        input logic b,
        input logic s
    );
        return s ? b : a;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// regfile_bypass bus: read/write selects, write data and read results.
// Optional bypass (REGFILE_BYPASS_EN) changes no signals here.
interface regfile_bypass_if #(
    parameter int WIDTH = regfile_bypass_pkg::REG_WIDTH,
    parameter int SELW  = regfile_bypass_pkg::REG_SEL_W
);

    logic [SELW-1:0]  read1RegSel;
    logic [SELW-1:0]  read2RegSel;
    logic [SELW-1:0]  writeRegSel;
    logic [WIDTH-1:0] writeData;
    logic             write;
    logic [WIDTH-1:0] read1Data;
    logic [WIDTH-1:0] read2Data;
    logic             err;

    modport master (
        output read1RegSel, read2RegSel, writeRegSel, writeData, write,
        input  read1Data, read2Data, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeRegSel, writeData, write,
        output read1Data, read2Data, err
    );

endinterface

// File: rtl/regfile_reg.sv
// One register-file word: per-bit flop fed by a hold/load 2:1 mux.
// Synchronous clear wins over load.
module regfile_reg
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Per-bit select between current value and incoming write data.
    always_comb begin
        w_next = r_q;
        for (int b = 0; b < WIDTH; b++) begin
            w_next[b] = mux2_1(r_q[b], i_d[b], i_we);
        end
    end

    // Storage flops with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_bypass.sv
// Register file top: write decoder, NREGS words, two read mux trees.
// Define REGFILE_BYPASS_EN to forward writeData to matching read ports.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = NUM_REGS,
    parameter int SELW  = REG_SEL_W
) (
    input logic            clk,
    input logic            rst,
    regfile_bypass_if.slave bus
);

    logic [NREGS-1:0] w_we;
    logic [WIDTH-1:0] w_q [NREGS];
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // One-hot write decode of writeRegSel, gated by write.
    always_comb begin
        w_we = '0;
        if (bus.write) begin
            w_we[bus.writeRegSel] = 1'b1;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        regfile_reg #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .i_we (w_we[g]),
            .i_d  (bus.writeData),
            .o_q  (w_q[g])
        );
    end

    // Read mux trees over the stored words.
    always_comb begin
        w_rd1 = w_q[bus.read1RegSel];
        w_rd2 = w_q[bus.read2RegSel];
    end

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Forward writeData to any port reading the register being written.
    always_comb begin
        w_hit1 = bus.write && !rst &&
                 (bus.read1RegSel == bus.writeRegSel);
        w_hit2 = bus.write && !rst &&
                 (bus.read2RegSel == bus.writeRegSel);
    end

    assign bus.read1Data = w_hit1 ? bus.writeData : w_rd1;
    assign bus.read2Data = w_hit2 ? bus.writeData : w_rd2;
`else
    assign bus.read1Data = w_rd1;
    assign bus.read2Data = w_rd2;
`endif

    // Unknown control inputs are only observable in simulation.
`ifdef SYNTHESIS
    assign bus.err = 1'b0;
`else
    assign bus.err = $isunknown({bus.write, bus.writeRegSel,
                                 bus.read1RegSel, bus.read2RegSel});
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass, one task per scenario.
// Same-cycle expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_bypass;
    import regfile_bypass_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    regfile_bypass_if bus ();

    regfile_bypass dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_write(input reg_sel_t sel, input reg_word_t data);
        @(negedge clk);
        bus.write       = 1'b1;
        bus.writeRegSel = sel;
        bus.writeData   = data;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reg_sel_t s1;
        reg_sel_t s2;
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            s1 = reg_sel_t'(i);
            s2 = reg_sel_t'(NUM_REGS - 1 - i);
            bus.read1RegSel = s1;
            bus.read2RegSel = s2;
            #1;
            n_total++;
            if (bus.read1Data !== 16'h0000)
                $display("FAIL reset_rd1 sel=%0d got=%h exp=0000", s1, bus.read1Data);
            else n_pass++;
            n_total++;
            if (bus.read2Data !== 16'h0000)
                $display("FAIL reset_rd2 sel=%0d got=%h exp=0000", s2, bus.read2Data);
            else n_pass++;
        end
    endtask

    task automatic test_write_all();
        reg_word_t exp;
        for (int i = 0; i < NUM_REGS; i++) begin
            do_write(reg_sel_t'(i), reg_word_t'(16'h1111 * i));
        end
        @(negedge clk);
        bus.read1RegSel = 3'd5;
        bus.read2RegSel = 3'd2;
        #1;
        n_total++;
        if (bus.read1Data !== 16'h5555)
            $display("FAIL wr_all_rd1 got=%h exp=5555", bus.read1Data);
        else n_pass++;
        n_total++;
        if (bus.read2Data !== 16'h2222)
            $display("FAIL wr_all_rd2 got=%h exp=2222", bus.read2Data);
        else n_pass++;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp = reg_word_t'(16'h1111 * i);
            bus.read1RegSel = reg_sel_t'(i);
            bus.read2RegSel = reg_sel_t'(i);
            #1;
            n_total++;
            if (bus.read1Data !== exp || bus.read2Data !== exp)
                $display("FAIL wr_all_same r%0d got=%h/%h exp=%h",
                         i, bus.read1Data, bus.read2Data, exp);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle();
        reg_word_t exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 16'h1234;
`else
        exp_pre = 16'hAAAA;
`endif
        do_write(3'd3, 16'hAAAA);
        @(negedge clk);
        bus.read1RegSel = 3'd3;
        bus.read2RegSel = 3'd3;
        bus.write       = 1'b1;
        bus.writeRegSel = 3'd3;
        bus.writeData   = 16'h1234;
        #1;
        n_total++;
        if (bus.read1Data !== exp_pre)
            $display("FAIL same_pre_rd1 got=%h exp=%h", bus.read1Data, exp_pre);
        else n_pass++;
        n_total++;
        if (bus.read2Data !== exp_pre)
            $display("FAIL same_pre_rd2 got=%h exp=%h", bus.read2Data, exp_pre);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        #1;
        n_total++;
        if (bus.read1Data !== 16'h1234)
            $display("FAIL same_post got=%h exp=1234", bus.read1Data);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst             = 1'b1;
        bus.write       = 1'b1;
        bus.writeRegSel = 3'd4;
        bus.writeData   = 16'hBEEF;
        bus.read1RegSel = 3'd4;
        bus.read2RegSel = 3'd5;
        #1;
        n_total++;
        if (bus.read1Data !== 16'h4444)
            $display("FAIL rstpri_pre got=%h exp=4444", bus.read1Data);
        else n_pass++;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.write = 1'b0;
        #1;
        n_total++;
        if (bus.read1Data !== 16'h0000)
            $display("FAIL rstpri_r4 got=%h exp=0000", bus.read1Data);
        else n_pass++;
        n_total++;
        if (bus.read2Data !== 16'h0000)
            $display("FAIL rstpri_r5 got=%h exp=0000", bus.read2Data);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_write(3'd6, 16'h00C3);
        @(negedge clk);
        bus.write       = 1'b0;
        bus.writeRegSel = 3'd6;
        bus.writeData   = 16'hFFFF;
        bus.read1RegSel = 3'd6;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.read1Data !== 16'h00C3)
                $display("FAIL hold c%0d got=%h exp=00c3", c, bus.read1Data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        do_write(3'd1, 16'h1111);
        do_reset();
        do_write(3'd2, 16'h2222);
        @(negedge clk);
        bus.read1RegSel = 3'd1;
        bus.read2RegSel = 3'd2;
        #1;
        n_total++;
        if (bus.read1Data !== 16'h0000)
            $display("FAIL midrst_r1 got=%h exp=0000", bus.read1Data);
        else n_pass++;
        n_total++;
        if (bus.read2Data !== 16'h2222)
            $display("FAIL midrst_r2 got=%h exp=2222", bus.read2Data);
        else n_pass++;
    endtask

    task automatic test_reg0();
        do_write(3'd0, 16'hDEAD);
        @(negedge clk);
        bus.read1RegSel = 3'd0;
        bus.read2RegSel = 3'd7;
        #1;
        n_total++;
        if (bus.read1Data !== 16'hDEAD)
            $display("FAIL reg0 got=%h exp=dead", bus.read1Data);
        else n_pass++;
        n_total++;
        if (bus.read2Data !== 16'h0000)
            $display("FAIL reg7_untouched got=%h exp=0000", bus.read2Data);
        else n_pass++;
    endtask

    task automatic test_err();
        logic [2:0] xs;
        logic       exp_err;
        @(negedge clk);
        bus.write       = 1'b0;
        bus.writeRegSel = 3'd0;
        bus.read1RegSel = 3'd1;
        bus.read2RegSel = 3'd2;
        #1;
        n_total++;
        if (bus.err !== 1'b0)
            $display("FAIL err_known got=%b exp=0", bus.err);
        else n_pass++;
        xs              = 3'bx;
        exp_err         = $isunknown(xs);
        bus.write       = 1'b1;
        bus.writeRegSel = xs;
        #1;
        n_total++;
        if (bus.err !== exp_err)
            $display("FAIL err_x got=%b exp=%b", bus.err, exp_err);
        else n_pass++;
        bus.write       = 1'b0;
        bus.writeRegSel = 3'd0;
        #1;
        n_total++;
        if (bus.err !== 1'b0)
            $display("FAIL err_clear got=%b exp=0", bus.err);
        else n_pass++;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst             = 1'b1;
        bus.write       = 1'b0;
        bus.writeRegSel = '0;
        bus.writeData   = '0;
        bus.read1RegSel = '0;
        bus.read2RegSel = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_write_all();
        test_same_cycle();
        test_reset_priority();
        test_hold();
        test_reset_midstream();
        test_reg0();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
